// File: rtl/rx_lane_fifo_if.sv
// Link/consumer bundle for rx_lane_fifo.
// serial_in    : LANES-wide serial link data (lane 0 carries header/parity)
// item_read    : consumer pops the head item
// valid        : FIFO non-empty
// parallel_out : head item, 0 when empty
// channel_busy : sender must not start a frame
// parity_err   : one-cycle pulse, frame dropped on parity mismatch
// overflow     : one-cycle pulse, frame dropped because FIFO was full at header
interface rx_lane_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 1
);
  logic [LANES-1:0] serial_in;
  logic             item_read;
  logic             valid;
  logic [WIDTH-1:0] parallel_out;
  logic             channel_busy;
  logic             parity_err;
  logic             overflow;

  // Sender/consumer side
  modport master (
    output serial_in, item_read,
    input  valid, parallel_out, channel_busy, parity_err, overflow
  );

  // Receiver side
  modport slave (
    input  serial_in, item_read,
    output valid, parallel_out, channel_busy, parity_err, overflow
  );
endinterface

// File: rtl/rx_lane_fifo.sv
// Serial-to-parallel flit receiver with optional even parity and a DEPTH-entry FIFO.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : rx_lane_fifo_if.slave (serial link in, FIFO head out, flow control and error pulses)
module rx_lane_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LANES    = 1,
  parameter int unsigned DEPTH    = 2,
  parameter bit          PARITY   = 1'b0,
  parameter int          routerid = -1,
  parameter string       port     = "unknown"
) (
  input logic           clk,
  input logic           reset,
  rx_lane_fifo_if.slave bus
);

  localparam int unsigned BEATS = (WIDTH + LANES - 1) / LANES;
  localparam int unsigned SW    = BEATS * LANES;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] PAR  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [SW-1:0]    shift_q, shift_d;
  logic             drop_q, drop_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             busy_q, busy_d;
  logic             perr_q, perr_d;
  logic             ovf_q, ovf_d;

  logic             complete;
  logic             par_bad;
  logic             wr_en;
  logic             pop;
  logic [WIDTH-1:0] wdata;
  logic [CW-1:0]    remain;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Frame FSM: header detect, beat assembly, parity check, completion decision
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    shift_d  = shift_q;
    drop_d   = drop_q;
    complete = 1'b0;
    par_bad  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.serial_in[0]) begin
          state_d = DATA;
          beat_d  = '0;
          shift_d = '0;
          // Only this block writes the FIFO, so fullness at header time is final
          drop_d  = (count_q == FULL_CNT);
        end
      end
      DATA: begin
        for (int unsigned b = 0; b < BEATS; b++) begin
          if (beat_q == BW'(b)) shift_d[b*LANES +: LANES] = bus.serial_in;
        end
        if (beat_q == LAST_BEAT) begin
          if (PARITY) begin
            state_d = PAR;
          end else begin
            state_d  = IDLE;
            complete = 1'b1;
          end
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      PAR: begin
        state_d  = IDLE;
        complete = 1'b1;
        par_bad  = (^shift_q[WIDTH-1:0]) ^ bus.serial_in[0];
      end
      default: state_d = IDLE;
    endcase
    // Last data beat is merged combinationally so the write lands on that edge
    wdata  = shift_d[WIDTH-1:0];
    wr_en  = complete & ~drop_q & ~par_bad;
    ovf_d  = complete & drop_q;
    perr_d = complete & ~drop_q & par_bad;
  end

  // FIFO pointers/count and registered view of the next head item
  always_comb begin
    pop     = bus.item_read & valid_q;
    head_d  = pop ? ptr_inc(head_q) : head_q;
    tail_d  = wr_en ? ptr_inc(tail_q) : tail_q;
    count_d = count_q + CW'(wr_en) - CW'(pop);
    remain  = count_q - CW'(pop);
    if (remain != '0) begin
      out_d = mem_q[head_d];
    end else if (wr_en) begin
      out_d = wdata;
    end else begin
      out_d = '0;
    end
    valid_d = (count_d != '0);
    busy_d  = (state_d != IDLE) | (count_d == FULL_CNT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      shift_q <= '0;
      drop_q  <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      shift_q <= shift_d;
      drop_q  <= drop_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      perr_q  <= perr_d;
      ovf_q   <= ovf_d;
      if (wr_en) mem_q[tail_q] <= wdata;
    end
  end

  assign bus.valid        = valid_q;
  assign bus.parallel_out = out_q;
  assign bus.channel_busy = busy_q;
  assign bus.parity_err   = perr_q;
  assign bus.overflow     = ovf_q;

`ifndef SYNTHESIS
  // Simulation trace of accepted items
  if (routerid > -1) begin : g_dbg
    always_ff @(posedge clk) begin
      if (reset && wr_en) $display("router %0d %s rx : %0h", routerid, port, wdata);
    end
  end
`endif

endmodule
